// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two requesters.
// Latches the winning operands, holds them for EXEC_CYCLES, screens bad ops, returns Res/Z/err.
module alu_arbiter #(
    parameter int unsigned W           = 32,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [W-1:0] op1_0,
    input  logic [W-1:0] op2_0,
    input  logic [3:0]   sel_0,
    output logic         gnt0,
    output logic         done0,
    input  logic         req1,
    input  logic [W-1:0] op1_1,
    input  logic [W-1:0] op2_1,
    input  logic [3:0]   sel_1,
    output logic         gnt1,
    output logic         done1,
    output logic [W-1:0] alu_OP1,
    output logic [W-1:0] alu_OP2,
    output logic [3:0]   alu_ALUSel,
    input  logic [W-1:0] alu_Res,
    input  logic         alu_Z,
    output logic [W-1:0] Res,
    output logic         Z,
    output logic         err,
    output logic         busy
);

    localparam int unsigned CW      = $clog2(EXEC_CYCLES + 1);
    localparam logic [3:0]  SEL_DIV = 4'h3;
    localparam logic [3:0]  SEL_MAX = 4'h6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic           r_ptr, w_ptr_nxt;
    logic           r_owner, w_owner_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [W-1:0]   r_op1, w_op1_nxt;
    logic [W-1:0]   r_op2, w_op2_nxt;
    logic [3:0]     r_sel, w_sel_nxt;
    logic [W-1:0]   r_res, w_res_nxt;
    logic           r_z, w_z_nxt;
    logic           r_err, w_err_nxt;
    logic           r_gnt0, w_gnt0_nxt;
    logic           r_gnt1, w_gnt1_nxt;
    logic           r_done0, w_done0_nxt;
    logic           r_done1, w_done1_nxt;
    logic           r_busy, w_busy_nxt;

    logic           w_pick1;
    logic           w_reject;

    // On a tie the requester that did not win last time goes first.
    assign w_pick1  = req1 && (!req0 || (r_ptr == 1'b0));
    assign w_reject = (r_sel > SEL_MAX) || ((r_sel == SEL_DIV) && (r_op2 == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_owner <= 1'b0;
            r_cnt   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_sel   <= '0;
            r_res   <= '0;
            r_z     <= 1'b0;
            r_err   <= 1'b0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op1   <= w_op1_nxt;
            r_op2   <= w_op2_nxt;
            r_sel   <= w_sel_nxt;
            r_res   <= w_res_nxt;
            r_z     <= w_z_nxt;
            r_err   <= w_err_nxt;
            r_gnt0  <= w_gnt0_nxt;
            r_gnt1  <= w_gnt1_nxt;
            r_done0 <= w_done0_nxt;
            r_done1 <= w_done1_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_op1_nxt   = r_op1;
        w_op2_nxt   = r_op2;
        w_sel_nxt   = r_sel;
        w_res_nxt   = r_res;
        w_z_nxt     = r_z;
        w_err_nxt   = r_err;
        w_gnt0_nxt  = 1'b0;
        w_gnt1_nxt  = 1'b0;
        w_done0_nxt = 1'b0;
        w_done1_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_owner_nxt = w_pick1;
                    w_gnt0_nxt  = !w_pick1;
                    w_gnt1_nxt  = w_pick1;
                    w_op1_nxt   = w_pick1 ? op1_1 : op1_0;
                    w_op2_nxt   = w_pick1 ? op2_1 : op2_0;
                    w_sel_nxt   = w_pick1 ? sel_1 : sel_0;
                    w_cnt_nxt   = CW'(EXEC_CYCLES - 1);
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    // Rejected ops never look at the ALU outputs.
                    w_res_nxt   = w_reject ? '0 : alu_Res;
                    w_z_nxt     = w_reject ? 1'b0 : alu_Z;
                    w_err_nxt   = w_reject;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = CW'(r_cnt - 1'b1);
                end
            end
            S_DONE: begin
                w_done0_nxt = !r_owner;
                w_done1_nxt = r_owner;
                w_ptr_nxt   = r_owner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign done0      = r_done0;
    assign done1      = r_done1;
    assign busy       = r_busy;
    assign alu_OP1    = r_op1;
    assign alu_OP2    = r_op2;
    assign alu_ALUSel = r_sel;
    assign Res        = r_res;
    assign Z          = r_z;
    assign err        = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench: one arbiter at EXEC_CYCLES=1, a second at EXEC_CYCLES=4,
// each driving a behavioural ALU.
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic         who;
        logic [W-1:0] res;
        logic         z;
        logic         err;
    } exp_t;

    logic clk;
    logic rst;

    logic         req0, req1, gnt0, gnt1, done0, done1;
    logic [W-1:0] op1_0, op2_0, op1_1, op2_1;
    logic [3:0]   sel_0, sel_1;
    logic [W-1:0] a_op1, a_op2, a_res, Res;
    logic [3:0]   a_sel;
    logic         a_z, Z, err, busy;

    logic         b_req0, b_req1, b_gnt0, b_gnt1, b_done0, b_done1;
    logic [W-1:0] b_op1_0, b_op2_0, b_op1_1, b_op2_1;
    logic [3:0]   b_sel_0, b_sel_1;
    logic [W-1:0] b_aop1, b_aop2, b_ares, b_Res;
    logic [3:0]   b_asel;
    logic         b_az, b_Z, b_err, b_busy;

    int   total;
    int   bad;
    exp_t sb[$];

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s);
        case (s)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return a * b;
            4'h3:    return (b == '0) ? '1 : a / b;
            4'h4:    return a | b;
            4'h5:    return a & b;
            4'h6:    return {{(W-1){1'b0}}, (a < b)};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign a_res  = alu_f(a_op1, a_op2, a_sel);
    assign a_z    = (a_res == '0);
    assign b_ares = alu_f(b_aop1, b_aop2, b_asel);
    assign b_az   = (b_ares == '0);

    alu_arbiter #(.W(W), .EXEC_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .op1_0(op1_0), .op2_0(op2_0), .sel_0(sel_0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .op1_1(op1_1), .op2_1(op2_1), .sel_1(sel_1), .gnt1(gnt1), .done1(done1),
        .alu_OP1(a_op1), .alu_OP2(a_op2), .alu_ALUSel(a_sel), .alu_Res(a_res), .alu_Z(a_z),
        .Res(Res), .Z(Z), .err(err), .busy(busy)
    );

    alu_arbiter #(.W(W), .EXEC_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req0(b_req0), .op1_0(b_op1_0), .op2_0(b_op2_0), .sel_0(b_sel_0), .gnt0(b_gnt0), .done0(b_done0),
        .req1(b_req1), .op1_1(b_op1_1), .op2_1(b_op2_1), .sel_1(b_sel_1), .gnt1(b_gnt1), .done1(b_done1),
        .alu_OP1(b_aop1), .alu_OP2(b_aop2), .alu_ALUSel(b_asel), .alu_Res(b_ares), .alu_Z(b_az),
        .Res(b_Res), .Z(b_Z), .err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Per-cycle bus checks: exclusivity and scoreboard pop on every done pulse.
    task automatic mon();
        exp_t e;
        if (rst) return;
        chk("exclusive", {gnt0 & gnt1, done0 & done1, b_gnt0 & b_gnt1, b_done0 & b_done1}, 64'd0);
        if (done0 || done1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {done1, done0}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("done_who", done1, e.who);
                chk("res", Res, e.res);
                chk("z", Z, e.z);
                chk("err", err, e.err);
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
    endtask

    task automatic do_op(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] s, input logic [W-1:0] exp_res, input logic exp_err);
        exp_t e;
        int   n;
        e.who = who;
        e.res = exp_err ? '0 : exp_res;
        e.z   = !exp_err && (exp_res == '0);
        e.err = exp_err;
        sb.push_back(e);
        if (!who) begin
            req0 = 1'b1; op1_0 = a; op2_0 = b; sel_0 = s;
        end else begin
            req1 = 1'b1; op1_1 = a; op2_1 = b; sel_1 = s;
        end
        n = 0;
        do begin cyc(); n++; end while (!(who ? gnt1 : gnt0) && n < 20);
        chk("gnt_latency", n, 64'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        // Operands changed after the grant must not reach the ALU.
        op1_0 = ~a; op2_0 = ~b; op1_1 = ~a; op2_1 = ~b;
        n = 0;
        do begin cyc(); n++; end while (!(done0 || done1) && n < 20);
        chk("done_latency", n, 64'd2);
        chk("alu_op1_held", a_op1, a);
        chk("alu_op2_held", a_op2, b);
    endtask

    initial begin
        logic order [4];
        int   g, n, busy_cnt, done_at;

        total = 0; bad = 0;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; op1_0 = '0; op2_0 = '0; op1_1 = '0; op2_1 = '0;
        sel_0 = '0; sel_1 = '0;
        b_req0 = 1'b0; b_req1 = 1'b0; b_op1_0 = '0; b_op2_0 = '0; b_op1_1 = '0; b_op2_1 = '0;
        b_sel_0 = '0; b_sel_1 = '0;
        cyc(); cyc();
        chk("rst_outputs", {gnt0, gnt1, done0, done1, busy, err, Z}, 64'd0);
        chk("rst_res", Res, 64'd0);
        chk("rst_alu", {a_op1, a_sel}, 64'd0);
        rst = 1'b0;
        cyc();

        // Zero flag through requester 1, then a plain add on requester 0.
        do_op(1'b1, 32'd9, 32'd9, 4'h1, 32'd0, 1'b0);
        do_op(1'b0, 32'd5, 32'd7, 4'h0, 32'd12, 1'b0);
        cyc();
        chk("res_holds", Res, 64'd12);

        // Abort mid-operation with async reset.
        req0 = 1'b1; op1_0 = 32'd3; op2_0 = 32'd3; sel_0 = 4'h0;
        cyc();
        chk("abort_gnt", gnt0, 64'd1);
        req0 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_clear", {busy, gnt0, done0, err}, 64'd0);
        chk("abort_res", Res, 64'd0);
        chk("abort_alu", a_op1, 64'd0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("no_done_after_abort", {done0, done1, busy}, 64'd0);
        do_op(1'b0, 32'd1, 32'd1, 4'h0, 32'd2, 1'b0);

        // Contention: both held, grants must alternate starting with requester 1.
        sb.push_back('{1'b1, 32'd42, 1'b0, 1'b0});
        sb.push_back('{1'b0, 32'd7, 1'b0, 1'b0});
        sb.push_back('{1'b1, 32'd42, 1'b0, 1'b0});
        sb.push_back('{1'b0, 32'd7, 1'b0, 1'b0});
        req0 = 1'b1; op1_0 = 32'd10; op2_0 = 32'd3; sel_0 = 4'h1;
        req1 = 1'b1; op1_1 = 32'd6;  op2_1 = 32'd7; sel_1 = 4'h2;
        g = 0; n = 0;
        while (g < 4 && n < 60) begin
            cyc(); n++;
            if (gnt0 || gnt1) begin
                order[g] = gnt1;
                g++;
                if (g == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("grant_count", g, 64'd4);
        chk("grant_order", {order[0], order[1], order[2], order[3]}, 64'b1010);
        n = 0;
        while (sb.size() != 0 && n < 20) begin cyc(); n++; end
        chk("sb_drained", sb.size(), 64'd0);
        cyc();

        // Screening: divide by zero, illegal codes at the boundary, legal ops clear err.
        do_op(1'b0, 32'd8, 32'd0, 4'h3, 32'd0, 1'b1);
        do_op(1'b0, 32'd8, 32'd2, 4'h9, 32'd0, 1'b1);
        do_op(1'b0, 32'd4, 32'd4, 4'h0, 32'd8, 1'b0);
        do_op(1'b1, 32'd1, 32'd1, 4'h7, 32'd0, 1'b1);
        do_op(1'b1, 32'd2, 32'd3, 4'h6, 32'd1, 1'b0);
        do_op(1'b0, 32'hF0, 32'h3C, 4'h5, 32'h30, 1'b0);

        // EXEC_CYCLES=4 instance: DIV 100/7 held for four cycles, done at cycle 6.
        b_req0 = 1'b1; b_op1_0 = 32'd100; b_op2_0 = 32'd7; b_sel_0 = 4'h3;
        busy_cnt = 0; done_at = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) begin
                chk("b_gnt", {b_gnt0, b_gnt1}, 64'b10);
                b_req0 = 1'b0; b_op1_0 = 32'd1; b_op2_0 = 32'd1; b_sel_0 = 4'h0;
            end
            if (c <= 4) chk("b_alu_stable", {b_aop1, b_aop2, b_asel}, {32'd100, 32'd7, 4'h3});
            if (b_busy) busy_cnt++;
            if (b_done0 || b_done1) begin
                done_at = c;
                chk("b_done_who", {b_done1, b_done0}, 64'b01);
                chk("b_res", b_Res, 64'd14);
                chk("b_flags", {b_Z, b_err}, 64'd0);
            end
        end
        chk("b_busy_cycles", busy_cnt, 64'd5);
        chk("b_done_cycle", done_at, 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
